tag_alloc: RTL
==============

TAG_ALLOC -- requirements
Module: tag_alloc

Interface
REQ-001 Parameter NUM_TAGS, default 2, number of downstream tag_logic instances; legal range 2..8.
REQ-002 Parameter TAG_W, default 1, tag index width; SHALL equal clog2(NUM_TAGS), or 1 when NUM_TAGS is 2.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 block_req  in  1  controller requests a new tile buffer; block_ready  out  1  the tag at alloc_ptr is free.
REQ-006 block_reuse, block_flush, block_bias_prev_sw, block_ddr_pe_sw  in  1 each  controller reuse, flush and switch qualifiers.
REQ-007 tag_req, tag_reuse, tag_flush  out  NUM_TAGS  one-hot per-tag pulses.
REQ-008 tag_bias_prev_sw, tag_ddr_pe_sw  out  1  broadcast copies of the block_* switch inputs.
REQ-009 tag_ready, ldmem_tag_ready, compute_tag_ready, stmem_tag_ready, next_compute_tag  in  NUM_TAGS  per-tag status.
REQ-010 ldmem_tag_done, compute_tag_done, stmem_tag_done  out  NUM_TAGS  routed one-hot done pulses.
REQ-011 ldmem_done, compute_done, stmem_done  in  1  stage completion pulses.
REQ-012 ldmem_tag, compute_tag, stmem_tag  out  TAG_W  current tag per stage; ldmem_valid, compute_valid, stmem_valid  out  1  pointed tag is ready for that stage.
REQ-013 all_idle  out  1  every tag_ready bit is high.

Function
REQ-014 Registered pointers alloc_ptr, last_ptr, ldmem_ptr, compute_ptr, stmem_ptr SHALL each wrap from NUM_TAGS-1 to 0 by explicit compare.
REQ-015 block_ready SHALL equal tag_ready[alloc_ptr], combinationally.
REQ-016 accept = block_req && block_ready; tag_req[alloc_ptr] SHALL pulse in the same cycle as accept.
REQ-017 On accept, the next edge SHALL set last_ptr to alloc_ptr, advance alloc_ptr, and set has_alloc to 1.
REQ-018 tag_reuse[last_ptr] SHALL pulse when block_reuse && has_alloc && !accept; in every other case block_reuse is dropped.
REQ-019 tag_flush[last_ptr] SHALL pulse when block_flush && has_alloc; a flush in the same cycle as an accept targets the previous last_ptr.
REQ-020 The *_valid outputs SHALL be {ldmem,compute,stmem}_tag_ready[ptr]; each *_tag output SHALL equal its ptr.
REQ-021 X_tag_done[X_ptr] SHALL equal X_done && X_valid, for X in ldmem, compute and stmem; a done pulse while not valid SHALL be dropped.
REQ-022 ldmem_ptr SHALL advance on a routed ldmem done.
REQ-023 stmem_ptr SHALL advance on a routed stmem done.
REQ-024 compute_ptr SHALL advance when next_compute_tag[compute_ptr] is high; a plain compute done does not advance it.
REQ-025 tag_bias_prev_sw and tag_ddr_pe_sw SHALL be wired straight from the block_* inputs with zero latency.
REQ-026 all_idle SHALL be the AND-reduction of tag_ready.
REQ-027 Routing paths SHALL be purely combinational; only pointers and has_alloc SHALL be flops.

Reset
REQ-028 While reset is low, all pointers and has_alloc SHALL be 0 immediately (asynchronous assert), and all pulse outputs SHALL be 0.
REQ-029 Reset release SHALL be synchronous to clk; no state SHALL survive a reset asserted mid-operation.

Structure
REQ-030 Tag-state encodings FREE=0, LDMEM=1, COMPUTE=2, COMPUTE_CHECK=3, STMEM=4 and a ptr_inc function SHALL live in the shared package tag_pkg.
REQ-031 One sub-module, tag_ptr (a wrapping counter with inc enable and reset), SHALL be instantiated five times.

Verification
REQ-032 With NUM_TAGS=2, two accepts at t0 and t1: tag_req=01 then 10, alloc_ptr 0->1->0, block_ready low once both tags are busy.
REQ-033 block_req with block_reuse in the same cycle: only tag_req pulses. A later block_reuse alone pulses tag_reuse[last_ptr].
REQ-034 ldmem_done with ldmem_valid=0: no ldmem_tag_done pulse, and ldmem_ptr stays unchanged.
REQ-035 next_compute_tag[0]=1 with compute_ptr=0: compute_ptr becomes 1, and compute_tag=1 on the next cycle.
REQ-036 With NUM_TAGS=3, stmem_ptr=2 and a routed stmem_done: stmem_ptr wraps to 0.
REQ-037 reset low mid-operation with all pointers nonzero: all pointers read 0 before the next clk edge, and all_idle follows tag_ready.

Source files
------------

// File: rtl/tag_pkg.sv
// ---------------------------------------------------------------------------
// tag_pkg
// Shared definitions for the tag allocator slice.
//   - tag_state_e : lifecycle states of a downstream tag_logic instance.
//   - TAG_W_MAX   : widest tag index supported (NUM_TAGS up to 8).
//   - ptr_inc     : wrapping increment of a tag pointer.
// ---------------------------------------------------------------------------
package tag_pkg;

    localparam int unsigned TAG_W_MAX = 3;

    typedef enum logic [2:0] {
        FREE          = 3'd0,
        LDMEM         = 3'd1,
        COMPUTE       = 3'd2,
        COMPUTE_CHECK = 3'd3,
        STMEM         = 3'd4
    } tag_state_e;

    // Next value of a tag pointer; wraps from num_tags-1 back to 0 by an
    // explicit compare so non-power-of-two tag counts work.
    function automatic logic [TAG_W_MAX-1:0] ptr_inc(
        input logic [TAG_W_MAX-1:0] ptr,
        input logic [TAG_W_MAX:0]   num_tags
    );
        logic [TAG_W_MAX:0] last_s;
        last_s = num_tags - 4'd1;
        if (ptr == last_s[TAG_W_MAX-1:0]) begin
            ptr_inc = 3'd0;
        end else begin
            ptr_inc = ptr + 3'd1;
        end
    endfunction

endpackage

// File: rtl/tag_ptr.sv
// ---------------------------------------------------------------------------
// tag_ptr
// Wrapping tag pointer: counts 0..NUM_TAGS-1 and wraps to 0.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset, clears the pointer to 0
//   inc   - advance the pointer on the next edge
//   ptr   - current pointer value (registered)
// ---------------------------------------------------------------------------
module tag_ptr
    import tag_pkg::*;
#(
    parameter int NUM_TAGS = 2,
    parameter int TAG_W    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [TAG_W-1:0] ptr
);

    logic [TAG_W-1:0] ptr_r;

    // Pointer register: cleared asynchronously, advances with wrap on inc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {TAG_W{1'b0}};
        end else if (inc) begin
            ptr_r <= TAG_W'(ptr_inc(TAG_W_MAX'(ptr_r), (TAG_W_MAX + 1)'(NUM_TAGS)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/tag_alloc.sv
// ---------------------------------------------------------------------------
// tag_alloc
// Hands out tile-buffer tags round-robin to the controller and routes the
// load / compute / store stage completions to the tag each stage points at.
// Ports:
//   clk, reset                      - clock, async active-low reset
//   block_req / block_ready         - controller request / tag at alloc_ptr free
//   block_reuse, block_flush        - reuse / flush of the last allocated tag
//   block_bias_prev_sw,
//   block_ddr_pe_sw                 - switch qualifiers, broadcast unchanged
//   tag_req, tag_reuse, tag_flush   - one-hot per-tag pulses
//   tag_bias_prev_sw, tag_ddr_pe_sw - broadcast switch copies
//   tag_ready, *_tag_ready          - per-tag status from the tag_logic blocks
//   next_compute_tag                - per-tag "compute finished, move on"
//   *_done                          - stage completion pulses
//   *_tag_done                      - done pulses routed to the stage's tag
//   *_tag, *_valid                  - current tag per stage and its readiness
//   all_idle                        - every tag reports ready
// Only the five pointers and has_alloc are state; all routing is
// combinational.
// ---------------------------------------------------------------------------
module tag_alloc
    import tag_pkg::*;
#(
    parameter int NUM_TAGS = 2,
    parameter int TAG_W    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                block_req,
    output logic                block_ready,
    input  logic                block_reuse,
    input  logic                block_flush,
    input  logic                block_bias_prev_sw,
    input  logic                block_ddr_pe_sw,
    output logic [NUM_TAGS-1:0] tag_req,
    output logic [NUM_TAGS-1:0] tag_reuse,
    output logic [NUM_TAGS-1:0] tag_flush,
    output logic                tag_bias_prev_sw,
    output logic                tag_ddr_pe_sw,
    input  logic [NUM_TAGS-1:0] tag_ready,
    input  logic [NUM_TAGS-1:0] ldmem_tag_ready,
    input  logic [NUM_TAGS-1:0] compute_tag_ready,
    input  logic [NUM_TAGS-1:0] stmem_tag_ready,
    input  logic [NUM_TAGS-1:0] next_compute_tag,
    output logic [NUM_TAGS-1:0] ldmem_tag_done,
    output logic [NUM_TAGS-1:0] compute_tag_done,
    output logic [NUM_TAGS-1:0] stmem_tag_done,
    input  logic                ldmem_done,
    input  logic                compute_done,
    input  logic                stmem_done,
    output logic [TAG_W-1:0]    ldmem_tag,
    output logic [TAG_W-1:0]    compute_tag,
    output logic [TAG_W-1:0]    stmem_tag,
    output logic                ldmem_valid,
    output logic                compute_valid,
    output logic                stmem_valid,
    output logic                all_idle
);

    // One-hot decode of a tag index.
    function automatic logic [NUM_TAGS-1:0] onehot(input logic [TAG_W-1:0] idx);
        onehot = NUM_TAGS'(1'b1) << idx;
    endfunction

    logic [TAG_W-1:0] alloc_ptr_s;
    logic [TAG_W-1:0] last_ptr_s;
    logic [TAG_W-1:0] ldmem_ptr_s;
    logic [TAG_W-1:0] compute_ptr_s;
    logic [TAG_W-1:0] stmem_ptr_s;
    logic             has_alloc_r;

    logic accept_s;
    logic last_inc_s;
    logic ldmem_fire_s;
    logic compute_fire_s;
    logic stmem_fire_s;
    logic compute_adv_s;

    // Accept and stage-fire decisions; every pulse is held off while reset
    // is asserted so nothing leaks out of a block that is being cleared.
    always_comb begin
        block_ready    = tag_ready[alloc_ptr_s];
        accept_s       = reset && block_req && block_ready;
        ldmem_valid    = ldmem_tag_ready[ldmem_ptr_s];
        compute_valid  = compute_tag_ready[compute_ptr_s];
        stmem_valid    = stmem_tag_ready[stmem_ptr_s];
        ldmem_fire_s   = reset && ldmem_done && ldmem_valid;
        compute_fire_s = reset && compute_done && compute_valid;
        stmem_fire_s   = reset && stmem_done && stmem_valid;
        compute_adv_s  = next_compute_tag[compute_ptr_s];
        // last_ptr trails alloc_ptr by one once anything has been allocated,
        // so it only needs to step on accepts after the first one.
        last_inc_s     = accept_s && has_alloc_r;
    end

    // One-hot pulse routing. Reuse loses to a same-cycle accept; flush
    // always targets the registered last_ptr, i.e. the tag allocated
    // before any accept happening this cycle.
    always_comb begin
        tag_req          = accept_s ? onehot(alloc_ptr_s) : {NUM_TAGS{1'b0}};
        tag_reuse        = (reset && block_reuse && has_alloc_r && !accept_s)
                           ? onehot(last_ptr_s) : {NUM_TAGS{1'b0}};
        tag_flush        = (reset && block_flush && has_alloc_r)
                           ? onehot(last_ptr_s) : {NUM_TAGS{1'b0}};
        ldmem_tag_done   = ldmem_fire_s   ? onehot(ldmem_ptr_s)   : {NUM_TAGS{1'b0}};
        compute_tag_done = compute_fire_s ? onehot(compute_ptr_s) : {NUM_TAGS{1'b0}};
        stmem_tag_done   = stmem_fire_s   ? onehot(stmem_ptr_s)   : {NUM_TAGS{1'b0}};
    end

    // Straight-through broadcasts and status.
    assign tag_bias_prev_sw = block_bias_prev_sw;
    assign tag_ddr_pe_sw    = block_ddr_pe_sw;
    assign all_idle         = &tag_ready;
    assign ldmem_tag        = ldmem_ptr_s;
    assign compute_tag      = compute_ptr_s;
    assign stmem_tag        = stmem_ptr_s;

    // Remembers whether any tag has been handed out since reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            has_alloc_r <= 1'b0;
        end else if (accept_s) begin
            has_alloc_r <= 1'b1;
        end else begin
            has_alloc_r <= has_alloc_r;
        end
    end

    tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_alloc_ptr (
        .clk(clk), .reset(reset), .inc(accept_s), .ptr(alloc_ptr_s)
    );

    tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_last_ptr (
        .clk(clk), .reset(reset), .inc(last_inc_s), .ptr(last_ptr_s)
    );

    tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_ldmem_ptr (
        .clk(clk), .reset(reset), .inc(ldmem_fire_s), .ptr(ldmem_ptr_s)
    );

    // Compute moves on when its tag signals completion of the whole compute
    // phase, not on every compute_done pulse.
    tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_compute_ptr (
        .clk(clk), .reset(reset), .inc(compute_adv_s), .ptr(compute_ptr_s)
    );

    tag_ptr #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_stmem_ptr (
        .clk(clk), .reset(reset), .inc(stmem_fire_s), .ptr(stmem_ptr_s)
    );

endmodule
